nand_serial_alu: RTL and testbench

Bit-serial 16-bit logic unit that owns one `Nand` gate instance and sequences it to evaluate NAND, NOT, AND, OR and XOR across a full word, one NAND evaluation per clock. It is the scheduler for the shared Nand primitive: it latches an operation, steps through each bit LSB-first, and walks each bit through the fixed NAND-only recipe for the opcode. Intermediate values are held in scratch flops. The unit is the area-minimal logic engine for small builds, sitting between a command source and a result consumer via valid/ready handshakes.

---
 rtl/nand_serial_alu.sv | 167 ++++++++++++++++
 tb/tb_nand_serial_alu.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/nand_serial_alu.sv
// Bit-serial logic unit: one shared NAND gate stepped through per-opcode recipes,
// LSB-first, one NAND evaluation per clock, with valid/ready on both sides.

module nand_gate (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = ~(a & b);
endmodule

module nand_serial_alu #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             err
);
    localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] OP_NAND = 3'd0;
    localparam logic [2:0] OP_NOT  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef enum logic [2:0] {SRC_A, SRC_B, SRC_T, SRC_X, SRC_Y} src_t;
    typedef enum logic [1:0] {DST_T, DST_X, DST_Y, DST_OUT} dst_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] a_q, b_q;
    logic [2:0]       op_q;
    logic [BIT_W-1:0] bit_idx;
    logic [1:0]       step;
    logic             t_q, x_q, y_q;
    src_t             src0, src1;
    dst_t             dst;
    logic             gate_in0, gate_in1, gate_out;
    logic             accept, legal_op, last_bit, last_step;

    assign accept    = in_valid && in_ready;
    assign legal_op  = (op <= OP_XOR);
    assign last_bit  = (bit_idx == BIT_W'(WIDTH - 1));
    assign last_step = (dst == DST_OUT);

    function automatic logic pick(src_t s, logic ab, logic bb, logic t, logic x, logic y);
        case (s)
            SRC_A:   return ab;
            SRC_B:   return bb;
            SRC_T:   return t;
            SRC_X:   return x;
            default: return y;
        endcase
    endfunction

    // Recipe table: which operands feed the gate at this step and where the result lands.
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        src0 = SRC_A;
        src1 = SRC_B;
        dst  = DST_OUT;
        case (op_q)
            OP_NOT: src1 = SRC_A;
            OP_AND: begin
                if (step == 2'd0) dst = DST_T;
                else begin
                    src0 = SRC_T;
                    src1 = SRC_T;
                end
            end
            OP_OR: begin
                case (step)
                    2'd0:    begin src1 = SRC_A; dst = DST_X; end
                    2'd1:    begin src0 = SRC_B; dst = DST_Y; end
                    default: begin src0 = SRC_X; src1 = SRC_Y; end
                endcase
            end
            OP_XOR: begin
                case (step)
                    2'd0:    dst = DST_T;
                    2'd1:    begin src1 = SRC_T; dst = DST_X; end
                    2'd2:    begin src0 = SRC_B; src1 = SRC_T; dst = DST_Y; end
                    default: begin src0 = SRC_X; src1 = SRC_Y; end
                endcase
            end
            default: ;
        endcase
    end

    assign gate_in0 = pick(src0, a_q[bit_idx], b_q[bit_idx], t_q, x_q, y_q);
    assign gate_in1 = pick(src1, a_q[bit_idx], b_q[bit_idx], t_q, x_q, y_q);

    nand_gate u_nand (
        .a (gate_in0),
        .b (gate_in1),
        .y (gate_out)
    );

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = legal_op ? RUN : DONE;
            end
            RUN:  if (last_step && last_bit) state_next = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            bit_idx <= '0;
            step    <= '0;
            t_q     <= 1'b0;
            x_q     <= 1'b0;
            y_q     <= 1'b0;
            out     <= '0;
            err     <= 1'b0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b;
            op_q    <= op;
            bit_idx <= '0;
            step    <= '0;
            out     <= '0;
            err     <= !legal_op;
        end else if (state == RUN) begin
            case (dst)
                DST_T:   t_q <= gate_out;
                DST_X:   x_q <= gate_out;
                DST_Y:   y_q <= gate_out;
                default: out[bit_idx] <= gate_out;
            endcase
            if (last_step) begin
                step <= '0;
                if (!last_bit) bit_idx <= bit_idx + 1'b1;
            end else begin
                step <= step + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_nand_serial_alu.sv
// Scoreboard bench for nand_serial_alu: results, latencies, handshakes, illegal ops,
// backpressure and asynchronous reset mid-operation.

module tb_nand_serial_alu;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready, out_valid, err;
    logic [W-1:0] out;

    nand_serial_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .err       (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] res;
        logic         err;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;
    int   k = 0;

    function automatic exp_t model(logic [2:0] o, logic [W-1:0] x, logic [W-1:0] y);
        exp_t e;
        e.err = 1'b0;
        case (o)
            3'd0:    begin e.res = ~(x & y); e.lat = W * 1; end
            3'd1:    begin e.res = ~x;       e.lat = W * 1; end
            3'd2:    begin e.res = x & y;    e.lat = W * 2; end
            3'd3:    begin e.res = x | y;    e.lat = W * 3; end
            3'd4:    begin e.res = x ^ y;    e.lat = W * 4; end
            default: begin e.res = '0; e.err = 1'b1; e.lat = 0; end
        endcase
        return e;
    endfunction

    task automatic send(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        in_valid = 1'b1;
        op = o;
        a = x;
        b = y;
        sb.push_back(model(o, x, y));
        @(posedge clk);
        @(negedge clk);
        k = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input string name);
        int   n = 0;
        exp_t e;
        while (!out_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!out_valid) $display("FAIL %s timeout: out_valid=0 after %0d cycles, required 1", name, n);
        else passed++;
        if (sb.size() == 0) begin
            checks++;
            $display("FAIL %s scoreboard empty", name);
            return;
        end
        e = sb.pop_front();
        checks++;
        if (out !== e.res) $display("FAIL %s out: got %h required %h", name, out, e.res);
        else passed++;
        checks++;
        if (err !== e.err) $display("FAIL %s err: got %b required %b", name, err, e.err);
        else passed++;
        checks++;
        if (cyc - k !== e.lat) $display("FAIL %s latency: got %0d required %0d", name, cyc - k, e.lat);
        else passed++;
    endtask

    task automatic consume(input string name);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL %s handoff: in_ready=%b out_valid=%b required 1/0", name, in_ready, out_valid);
        else passed++;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out !== '0 || err !== 1'b0)
            $display("FAIL reset: in_ready=%b out_valid=%b out=%h err=%b required 1/0/0000/0",
                     in_ready, out_valid, out, err);
        else passed++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_ops();
        logic [2:0]   ops [5] = '{3'd4, 3'd2, 3'd3, 3'd1, 3'd0};
        logic [W-1:0] as  [5] = '{16'hA5A5, 16'hFFFF, 16'h00F0, 16'h0000, 16'hFFFF};
        logic [W-1:0] bs  [5] = '{16'h0FF0, 16'h1234, 16'h0F00, 16'h5555, 16'hFFFF};
        for (int i = 0; i < 5; i++) begin
            send(ops[i], as[i], bs[i]);
            wait_result($sformatf("op%0d", ops[i]));
            consume($sformatf("op%0d", ops[i]));
        end
    endtask

    task automatic test_midrun_change();
        send(3'd4, 16'h1357, 16'h2468);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            a = W'($urandom);
            b = W'($urandom);
            op = 3'd2;
            in_valid = 1'b1;
        end
        checks++;
        if (in_ready !== 1'b0) $display("FAIL midrun in_ready: got %b required 0", in_ready);
        else passed++;
        in_valid = 1'b0;
        wait_result("midrun");
        consume("midrun");
    endtask

    task automatic test_illegal();
        send(3'd6, 16'hBEEF, 16'hCAFE);
        wait_result("illegal");
        consume("illegal");
        send(3'd0, 16'h0F0F, 16'h00FF);
        wait_result("after_illegal");
        consume("after_illegal");
    endtask

    task automatic test_backpressure();
        send(3'd2, 16'hFFFF, 16'h1234);
        wait_result("bp");
        in_valid = 1'b1;
        op = 3'd0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (out !== 16'h1234 || out_valid !== 1'b1 || in_ready !== 1'b0 || err !== 1'b0)
                $display("FAIL bp hold %0d: out=%h out_valid=%b in_ready=%b err=%b required 1234/1/0/0",
                         i, out, out_valid, in_ready, err);
            else passed++;
        end
        in_valid = 1'b0;
        consume("bp");
    endtask

    task automatic test_async_reset();
        send(3'd4, 16'hA5A5, 16'h0FF0);
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1 || err !== 1'b0)
            $display("FAIL async_reset: out=%h out_valid=%b in_ready=%b err=%b required 0000/0/1/0",
                     out, out_valid, in_ready, err);
        else passed++;
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        send(3'd2, 16'h00FF, 16'h0F0F);
        wait_result("post_reset_and");
        consume("post_reset_and");
    endtask

    initial begin
        test_reset();
        test_ops();
        test_midrun_change();
        test_illegal();
        test_backpressure();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
